// File: rtl/drs_run_ctrl.sv
// Run sequencer ahead of the DRS readout controller: configure/start,
// arm, forward one trigger per readout, holdoff, and hung-readout recovery.
module drs_run_ctrl #(
  parameter int CONFIG_WAIT  = 127,
  parameter int START_WAIT   = 127,
  parameter int HOLDOFF_BITS = 16,
  parameter int CNT_BITS     = 32,
  parameter int BUSY_TIMEOUT = 65535
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    run_i,
  input  logic                    trigger_i,
  input  logic [HOLDOFF_BITS-1:0] holdoff_i,
  input  logic                    drs_busy_i,
  output logic                    drs_configure_o,
  output logic                    drs_start_o,
  output logic                    drs_trigger_o,
  output logic                    drs_reinit_o,
  output logic                    armed_o,
  output logic [2:0]              state_o,
  output logic [CNT_BITS-1:0]     accepted_cnt_o,
  output logic [CNT_BITS-1:0]     rejected_cnt_o,
  output logic                    timeout_o
);

  localparam int CW  = (CONFIG_WAIT < 1) ? 1 : CONFIG_WAIT;
  localparam int SW  = (START_WAIT < 1) ? 1 : START_WAIT;
  localparam int BT  = (BUSY_TIMEOUT < 1) ? 1 : BUSY_TIMEOUT;
  localparam int MW1 = (CW > SW) ? CW : SW;
  localparam int MW  = (MW1 > BT) ? MW1 : BT;
  localparam int TW  = $clog2(MW + 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CONFIG   = 3'd1,
    S_CFG_WAIT = 3'd2,
    S_START    = 3'd3,
    S_STARTUP  = 3'd4,
    S_ARMED    = 3'd5,
    S_READOUT  = 3'd6,
    S_HOLDOFF  = 3'd7
  } state_e;

  state_e                  state_q, state_d;
  logic [TW-1:0]           timer_q, timer_d;
  logic [HOLDOFF_BITS-1:0] hold_q, hold_d;
  logic                    phase_q, phase_d;
  logic                    trig_q;
  logic [CNT_BITS-1:0]     acc_q, acc_d;
  logic [CNT_BITS-1:0]     rej_q, rej_d;
  logic                    tmo_q, tmo_d;
  logic                    cfg_q, start_q, fwd_q, reinit_q, armed_q;
  logic                    fwd_d, reinit_d;
  logic                    trig_edge, ro_done, ro_tmo;

  function automatic logic [CNT_BITS-1:0] sat_inc(
    input logic [CNT_BITS-1:0] v
  );
    return (&v) ? v : v + CNT_BITS'(1);
  endfunction

  assign trig_edge = trigger_i & ~trig_q;
  assign ro_done   = phase_q & ~drs_busy_i;
  assign ro_tmo    = (timer_q == TW'(BT - 1));

  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    phase_d  = phase_q;
    acc_d    = acc_q;
    rej_d    = rej_q;
    tmo_d    = tmo_q;
    fwd_d    = 1'b0;
    reinit_d = 1'b0;
    timer_d  = timer_q + TW'(1);

    if (trig_edge && run_i &&
        state_q != S_ARMED && state_q != S_IDLE)
      rej_d = sat_inc(rej_q);

    if (!run_i && state_q != S_READOUT) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          state_d = S_CONFIG;
          acc_d   = '0;
          rej_d   = '0;
          tmo_d   = 1'b0;
        end
        S_CONFIG: state_d = S_CFG_WAIT;
        S_CFG_WAIT:
          if (timer_q == TW'(CW - 1)) state_d = S_START;
        S_START: state_d = S_STARTUP;
        S_STARTUP:
          if (timer_q == TW'(SW - 1)) state_d = S_ARMED;
        S_ARMED:
          if (trig_edge) begin
            state_d = S_READOUT;
            fwd_d   = 1'b1;
            acc_d   = sat_inc(acc_q);
          end
        S_READOUT: begin
          if (!phase_q && drs_busy_i) phase_d = 1'b1;
          // a completed readout wins over a coincident timeout
          if (ro_done) begin
            state_d = run_i ? S_HOLDOFF : S_IDLE;
            hold_d  = holdoff_i;
          end else if (ro_tmo) begin
            state_d  = run_i ? S_CONFIG : S_IDLE;
            reinit_d = 1'b1;
            tmo_d    = 1'b1;
          end
        end
        S_HOLDOFF: begin
          if (hold_q <= HOLDOFF_BITS'(1)) state_d = S_ARMED;
          else hold_d = hold_q - HOLDOFF_BITS'(1);
        end
        default: state_d = S_IDLE;
      endcase
    end

    if (state_d != state_q) begin
      timer_d = '0;
      phase_d = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      timer_q  <= '0;
      hold_q   <= '0;
      phase_q  <= 1'b0;
      trig_q   <= 1'b0;
      acc_q    <= '0;
      rej_q    <= '0;
      tmo_q    <= 1'b0;
      cfg_q    <= 1'b0;
      start_q  <= 1'b0;
      fwd_q    <= 1'b0;
      reinit_q <= 1'b0;
      armed_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      hold_q   <= hold_d;
      phase_q  <= phase_d;
      trig_q   <= trigger_i;
      acc_q    <= acc_d;
      rej_q    <= rej_d;
      tmo_q    <= tmo_d;
      cfg_q    <= (state_d == S_CONFIG);
      start_q  <= (state_d == S_START);
      fwd_q    <= fwd_d;
      reinit_q <= reinit_d;
      armed_q  <= (state_d == S_ARMED);
    end
  end

  assign drs_configure_o = cfg_q;
  assign drs_start_o     = start_q;
  assign drs_trigger_o   = fwd_q;
  assign drs_reinit_o    = reinit_q;
  assign armed_o         = armed_q;
  assign state_o         = state_q;
  assign accepted_cnt_o  = acc_q;
  assign rejected_cnt_o  = rej_q;
  assign timeout_o       = tmo_q;

endmodule

// File: tb/tb_drs_run_ctrl.sv
// Directed and randomized bench for drs_run_ctrl against a
// countdown-based behavioural model of the run sequencer.
module tb_drs_run_ctrl;

  localparam int CWAIT = 4;
  localparam int SWAIT = 4;
  localparam int BTO   = 20;
  localparam int CB    = 4;
  localparam int HB    = 16;
  localparam int CMAX  = (1 << CB) - 1;

  localparam int M_IDLE = 0, M_CONFIG = 1, M_CFGW = 2, M_START = 3;
  localparam int M_STUP = 4, M_ARMED = 5, M_RO = 6, M_HOLD = 7;

  logic          clock = 1'b0;
  logic          reset, run, trg, busy;
  logic [HB-1:0] ho;
  logic          cfg_o, start_o, trig_o, reinit_o, armed_o, tmo_o;
  logic [2:0]    state_o;
  logic [CB-1:0] acc_o, rej_o;

  int checks = 0;
  int errors = 0;

  int   ms, m_left, m_ro, m_acc, m_rej;
  logic m_seen, m_tmo, m_tprev;
  logic e_cfg, e_start, e_trig, e_reinit, e_armed;
  int   trig_seen, cfg_seen, start_seen;

  drs_run_ctrl #(
    .CONFIG_WAIT (CWAIT),
    .START_WAIT  (SWAIT),
    .HOLDOFF_BITS(HB),
    .CNT_BITS    (CB),
    .BUSY_TIMEOUT(BTO)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .run_i          (run),
    .trigger_i      (trg),
    .holdoff_i      (ho),
    .drs_busy_i     (busy),
    .drs_configure_o(cfg_o),
    .drs_start_o    (start_o),
    .drs_trigger_o  (trig_o),
    .drs_reinit_o   (reinit_o),
    .armed_o        (armed_o),
    .state_o        (state_o),
    .accepted_cnt_o (acc_o),
    .rejected_cnt_o (rej_o),
    .timeout_o      (tmo_o)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  task automatic m_reset();
    ms = M_IDLE; m_left = 0; m_ro = 0; m_acc = 0; m_rej = 0;
    m_seen = 0; m_tmo = 0; m_tprev = 0;
    e_cfg = 0; e_start = 0; e_trig = 0; e_reinit = 0; e_armed = 0;
  endtask

  task automatic m_clk();
    int   ns;
    logic edg;
    if (reset) begin
      m_reset();
      return;
    end
    edg = trg && !m_tprev;
    ns = ms;
    e_reinit = 0;
    if (edg && run && ms != M_ARMED && ms != M_IDLE)
      m_rej = sat(m_rej + 1);
    if (!run && ms != M_RO) ns = M_IDLE;
    else case (ms)
      M_IDLE: begin
        ns = M_CONFIG; m_acc = 0; m_rej = 0; m_tmo = 0;
      end
      M_CONFIG: begin ns = M_CFGW; m_left = CWAIT; end
      M_CFGW: begin
        m_left--;
        if (m_left == 0) ns = M_START;
      end
      M_START: begin ns = M_STUP; m_left = SWAIT; end
      M_STUP: begin
        m_left--;
        if (m_left == 0) ns = M_ARMED;
      end
      M_ARMED: if (edg) begin
        ns = M_RO; m_acc = sat(m_acc + 1); m_ro = 0; m_seen = 0;
      end
      M_RO: begin
        m_ro++;
        if (m_seen && !busy) begin
          ns = run ? M_HOLD : M_IDLE;
          m_left = (ho == 0) ? 1 : int'(ho);
        end else if (m_ro == BTO) begin
          e_reinit = 1; m_tmo = 1;
          ns = run ? M_CONFIG : M_IDLE;
        end
        if (busy) m_seen = 1;
      end
      default: begin
        m_left--;
        if (m_left <= 0) ns = M_ARMED;
      end
    endcase
    e_trig  = (ms == M_ARMED) && (ns == M_RO);
    e_cfg   = (ns == M_CONFIG);
    e_start = (ns == M_START);
    e_armed = (ns == M_ARMED);
    ms = ns;
    m_tprev = trg;
  endtask

  function automatic logic [31:0] exp_vec();
    logic [2:0]    s;
    logic [CB-1:0] a, r;
    s = 3'(ms); a = CB'(m_acc); r = CB'(m_rej);
    return 32'({e_cfg, e_start, e_trig, e_reinit, e_armed,
                m_tmo, s, a, r});
  endfunction

  function automatic logic [31:0] obs_vec();
    return 32'({cfg_o, start_o, trig_o, reinit_o, armed_o,
                tmo_o, state_o, acc_o, rej_o});
  endfunction

  task automatic step();
    @(posedge clock);
    m_clk();
    #1;
    chk("cycle", obs_vec(), exp_vec());
    trig_seen  += int'(trig_o);
    cfg_seen   += int'(cfg_o);
    start_seen += int'(start_o);
  endtask

  initial begin
    int dly, len;
    reset = 1; run = 0; trg = 0; busy = 0; ho = '0;
    trig_seen = 0; cfg_seen = 0; start_seen = 0;
    m_reset();
    repeat (2) step();
    chk("rst_zero", obs_vec(), 32'd0);
    reset = 0;
    step();

    // startup sequence
    run = 1;
    step();
    chk("t1_cfg", 32'(cfg_o), 32'd1);
    repeat (5) step();
    chk("t1_start", 32'(start_o), 32'd1);
    repeat (5) step();
    chk("t1_armed", 32'(armed_o), 32'd1);
    chk("t1_state", 32'(state_o), 32'd5);

    // one accepted trigger with holdoff 3
    trig_seen = 0;
    trg = 1; step();
    chk("t2_trig", 32'(trig_o), 32'd1);
    trg = 0; step();
    chk("t2_trig_once", 32'(trig_o), 32'd0);
    step();
    busy = 1; repeat (10) step();
    busy = 0; ho = 16'd3; step();
    chk("t2_hold", 32'(state_o), 32'd7);
    repeat (2) step();
    chk("t2_not_armed", 32'(armed_o), 32'd0);
    step();
    chk("t2_rearmed", 32'(armed_o), 32'd1);
    chk("t2_acc", 32'(acc_o), 32'd1);
    chk("t2_pulses", 32'(trig_seen), 32'd1);

    // rejection during readout and holdoff
    trig_seen = 0;
    trg = 1; step();
    trg = 0; step();
    busy = 1;
    repeat (3) begin trg = 1; step(); trg = 0; step(); end
    busy = 0; ho = 16'd10; step();
    repeat (2) begin trg = 1; step(); trg = 0; step(); end
    repeat (10) step();
    chk("t3_rej", 32'(rej_o), 32'd5);
    chk("t3_acc", 32'(acc_o), 32'd2);
    chk("t3_pulses", 32'(trig_seen), 32'd1);
    chk("t3_armed", 32'(armed_o), 32'd1);

    // readout timeout and recovery
    ho = '0;
    trg = 1; step();
    trg = 0; repeat (19) step();
    chk("t4_no_reinit", 32'(reinit_o), 32'd0);
    step();
    chk("t4_reinit", 32'(reinit_o), 32'd1);
    chk("t4_recfg", 32'(cfg_o), 32'd1);
    chk("t4_tmo", 32'(tmo_o), 32'd1);
    step();
    chk("t4_reinit_once", 32'(reinit_o), 32'd0);
    repeat (4) step();
    chk("t4_start", 32'(start_o), 32'd1);
    repeat (5) step();
    chk("t4_armed", 32'(armed_o), 32'd1);

    // stop while busy
    trg = 1; step();
    trg = 0; step();
    busy = 1; repeat (3) step();
    run = 0; repeat (3) step();
    chk("t5_still_ro", 32'(state_o), 32'd6);
    busy = 0; step();
    chk("t5_idle", 32'(state_o), 32'd0);
    cfg_seen = 0; start_seen = 0;
    repeat (10) step();
    chk("t5_no_cfg", 32'(cfg_seen), 32'd0);
    chk("t5_no_start", 32'(start_seen), 32'd0);

    // async reset in ARMED, then counter saturation
    run = 1; repeat (11) step();
    chk("t6_armed", 32'(armed_o), 32'd1);
    #2 reset = 1;
    m_reset();
    #1 chk("t6_async_rst", obs_vec(), 32'd0);
    step();
    reset = 0;
    repeat (11) step();
    chk("t6_rearmed", 32'(armed_o), 32'd1);
    repeat (20) begin
      trg = 1; step();
      trg = 0; step();
      busy = 1; step(); step();
      busy = 0; step();
      step();
    end
    chk("t6_sat", 32'(acc_o), 32'd15);

    // randomized run with a simple DRS busy emulation
    dly = 0; len = 0;
    repeat (3000) begin
      if (run && $urandom_range(0, 199) == 0) run = 0;
      else if (!run && $urandom_range(0, 4) == 0) run = 1;
      if ($urandom_range(0, 3) == 0) trg = ~trg;
      ho = HB'($urandom_range(0, 6));
      if (dly > 0) begin
        dly--; busy = 0;
      end else if (len > 0) begin
        len--; busy = 1;
      end else busy = 0;
      step();
      if (e_trig && $urandom_range(0, 4) != 0) begin
        dly = $urandom_range(0, 4);
        len = $urandom_range(1, 12);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/drs_run_ctrl.md
Name: drs_run_ctrl

Overview:
Run sequencer that sits in front of the drs readout controller. It issues the configure and start pulses in order and arms the DRS for triggers. It forwards one external trigger per readout and holds off further triggers until the DRS is idle and a programmable holdoff has elapsed. It also counts accepted and rejected triggers, and recovers a hung readout by pulsing reinit and reconfiguring.

Parameters:
CONFIG_WAIT, 127, cycles to wait after drs_configure_o before issuing drs_start_o
START_WAIT, 127, cycles to wait after drs_start_o before entering ARMED
HOLDOFF_BITS, 16, width of holdoff_i
CNT_BITS, 32, width of the trigger counters
BUSY_TIMEOUT, 65535, maximum READOUT cycles before recovery

Ports:
clock  in  1  system clock (33 MHz domain)
reset  in  1  asynchronous, active-high reset
run_i  in  1  level; 1 = run enabled
trigger_i  in  1  external trigger, synchronous to clock; rising edge significant
holdoff_i  in  HOLDOFF_BITS  cycles to hold off after DRS busy falls
drs_busy_i  in  1  busy_o from drs
drs_configure_o  out  1  one-cycle pulse to drs_ctl_configure_drs
drs_start_o  out  1  one-cycle pulse to drs_ctl_start
drs_trigger_o  out  1  one-cycle pulse to drs trigger_i
drs_reinit_o  out  1  one-cycle pulse to drs_ctl_reinit
armed_o  out  1  high while in ARMED
state_o  out  3  current state encoding
accepted_cnt_o  out  CNT_BITS  triggers forwarded
rejected_cnt_o  out  CNT_BITS  trigger edges dropped while running
timeout_o  out  1  sticky; a READOUT timeout occurred

Behaviour:
- Reset (async assert, released synchronously to clock): state IDLE; all outputs 0; counters 0; internal trigger_q 0.
- trig_edge = trigger_i & ~trigger_q, where trigger_q is trigger_i registered.
- States and encodings: IDLE=0, CONFIG=1, CFG_WAIT=2, START=3, STARTUP=4, ARMED=5, READOUT=6, HOLDOFF=7.
- IDLE:
  - When run_i=1 -> CONFIG.
  - On that transition, clear both counters and timeout_o.
- CONFIG: drs_configure_o=1 for exactly this cycle -> CFG_WAIT.
- CFG_WAIT: count CONFIG_WAIT cycles -> START.
- START: drs_start_o=1 for this cycle -> STARTUP.
- STARTUP: count START_WAIT cycles -> ARMED.
- ARMED:
  - armed_o=1.
  - On trig_edge: drs_trigger_o=1 in the next cycle; accepted_cnt_o increments; go to READOUT.
  - trig_edge counts as accepted only if the registered state is ARMED in the cycle the edge is detected.
- READOUT: the timer is cleared on entry.
  - Phase A waits for drs_busy_i=1; phase B waits for drs_busy_i=0.
  - On busy falling in phase B -> HOLDOFF.
  - If the timer reaches BUSY_TIMEOUT in either phase:
    - drs_reinit_o pulses 1 cycle.
    - timeout_o is set.
    - Go to CONFIG, which reconfigures and restarts.
- HOLDOFF:
  - Count holdoff_i cycles, sampled on entry, then go to ARMED.
  - holdoff_i=0 -> ARMED on the next cycle.
- Rejected triggers: any trig_edge while run_i=1 and state is not ARMED increments rejected_cnt_o.
- Counters saturate at all-ones and never wrap.
- run_i=0:
  - From any state other than READOUT -> IDLE next cycle.
  - From READOUT, complete the readout (busy fall or timeout), then go to IDLE instead of HOLDOFF/CONFIG.
  - The reinit pulse is still issued on timeout.
  - Trigger edges in IDLE are not counted.
- Reset mid-run: immediate IDLE, no pulses emitted; counters cleared.
- All outputs are registered. Pulse outputs are never high for two consecutive cycles.

Test Plan:
1. Startup sequence (CONFIG_WAIT=4, START_WAIT=4): reset released, run_i=1 at cycle 0 -> drs_configure_o at cycle 1; drs_start_o 5 cycles later; armed_o high 5 cycles after that.
2. Trigger acceptance: ARMED, trigger edge, drs_busy_i high 10 cycles starting 2 cycles later, holdoff_i=3 -> exactly one drs_trigger_o pulse; accepted_cnt_o=1; armed_o returns 3 cycles after busy falls.
3. Rejection: 5 trigger edges during READOUT/HOLDOFF -> rejected_cnt_o=5, accepted_cnt_o unchanged, no extra drs_trigger_o.
4. Timeout (BUSY_TIMEOUT=20): trigger accepted, drs_busy_i held 0 -> drs_reinit_o pulse at 20 READOUT cycles; timeout_o=1; then drs_configure_o, drs_start_o, ARMED again.
5. Stop during readout: run_i dropped mid-busy -> state stays READOUT until busy falls, then IDLE; no further configure/start pulses.
6. Async reset in ARMED, and counter saturation with CNT_BITS=4 -> reset gives immediate IDLE with zero outputs; 20 accepted triggers leave accepted_cnt_o at 15.
